// File: rtl/top_module_gen.sv
`default_nettype none
// ============================================================================
// Module   : top_module_gen
// Purpose  : Free-running framed serial pattern generator. Emits repeating
//            frames of: 8-bit sync word (MSB first), PRBS-7 payload
//            (x^7 + x^6 + 1), then an idle gap of zeros.
// Ports    : clk   - single clock, rising-edge active
//            reset - asynchronous, active-high reset
//            y     - registered serial pattern output
// Revision : 1.0 - initial release
// ============================================================================
module top_module_gen #(
  parameter logic [7:0] SYNC_WORD   = 8'hA5,
  parameter int         PAYLOAD_LEN = 24,     // 1..255
  parameter int         GAP_LEN     = 4,      // 0..255, 0 = no gap
  parameter logic [6:0] PRBS_SEED   = 7'h7F   // must be nonzero
) (
  input  logic clk,
  input  logic reset,
  output logic y
);

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_GAP     = 2'd2
  } state_t;

  // Counter compares are against "last index" values so that a 255-bit
  // payload or gap never needs the counter to reach 256.
  localparam logic [7:0] c_payload_last = 8'(PAYLOAD_LEN - 1);
  localparam logic [7:0] c_gap_last     = (GAP_LEN == 0) ? 8'd0 : 8'(GAP_LEN - 1);
  // With no gap the payload hands straight back to the sync word.
  localparam state_t     c_after_payload = (GAP_LEN == 0) ? ST_SYNC : ST_GAP;

  state_t     r_state;
  logic [7:0] r_bit_cnt;
  logic [6:0] r_lfsr;
  logic       r_y;

  state_t     w_state_nxt;
  logic [7:0] w_bit_cnt_nxt;
  logic [6:0] w_lfsr_nxt;
  logic       w_y_nxt;
  logic [2:0] w_sync_idx;

  // Sync word goes out MSB first: bit_cnt 0 selects bit 7.
  assign w_sync_idx = 3'd7 - r_bit_cnt[2:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_SYNC;
      r_bit_cnt <= 8'd0;
      r_lfsr    <= PRBS_SEED;
      r_y       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_lfsr    <= w_lfsr_nxt;
      r_y       <= w_y_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_lfsr_nxt    = r_lfsr;
    w_y_nxt       = 1'b0;

    case (r_state)
      ST_SYNC: begin
        w_y_nxt = SYNC_WORD[w_sync_idx];
        if (r_bit_cnt == 8'd7) begin
          w_state_nxt   = ST_PAYLOAD;
          w_bit_cnt_nxt = 8'd0;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 8'd1;
        end
      end

      ST_PAYLOAD: begin
        // Output the MSB, then shift in the x^7 + x^6 + 1 feedback. The LFSR
        // is never reseeded, so the stream continues across frames.
        w_y_nxt    = r_lfsr[6];
        w_lfsr_nxt = {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
        if (r_bit_cnt == c_payload_last) begin
          w_state_nxt   = c_after_payload;
          w_bit_cnt_nxt = 8'd0;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 8'd1;
        end
      end

      ST_GAP: begin
        w_y_nxt = 1'b0;
        if (r_bit_cnt == c_gap_last) begin
          w_state_nxt   = ST_SYNC;
          w_bit_cnt_nxt = 8'd0;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 8'd1;
        end
      end

      default: begin
        w_state_nxt   = ST_SYNC;
        w_bit_cnt_nxt = 8'd0;
      end
    endcase
  end

  assign y = r_y;

endmodule
`default_nettype wire

// File: tb/tb_top_module_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_top_module_gen
// Purpose  : Self-checking bench for top_module_gen. Three instances share
//            clock and reset: default framing, a 1-bit payload with no gap,
//            and maximum 255-bit payload and gap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_top_module_gen;

  logic clk;
  logic reset;
  logic y_a;
  logic y_b;
  logic y_c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic rst;
    logic exp_y;
  } vec_t;

  vec_t tbl[0:39];

  logic [7:0]  c_sync     = 8'hA5;
  // Hand-derived first 24 PRBS-7 bits from seed 7F (bit 1 in the MSB).
  logic [23:0] c_pay_hand = 24'hFE0418;

  logic prbs[0:126];
  logic pb[0:299];

  top_module_gen dut_a (
    .clk   (clk),
    .reset (reset),
    .y     (y_a)
  );

  top_module_gen #(
    .PAYLOAD_LEN (1),
    .GAP_LEN     (0)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .y     (y_b)
  );

  top_module_gen #(
    .PAYLOAD_LEN (255),
    .GAP_LEN     (255)
  ) dut_c (
    .clk   (clk),
    .reset (reset),
    .y     (y_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int t, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %0b expected %0b", name, t, act, exp);
    end
  endtask

  // Reference frame model: t counts cycles after reset release (0 = first
  // sync bit).
  function automatic logic model_y(input int t, input int pl, input int gl);
    int per;
    int f;
    int p;
    per = 8 + pl + gl;
    f   = t / per;
    p   = t % per;
    if (p < 8)
      return c_sync[7 - p];
    else if (p < 8 + pl)
      return prbs[(f * pl + p - 8) % 127];
    else
      return 1'b0;
  endfunction

  task automatic check_bc(input string name, input int t);
    check({name, "_b"}, t, y_b, model_y(t, 1, 0));
    check({name, "_c"}, t, y_c, model_y(t, 255, 255));
    if ((t % 9) == 8 && (t / 9) < 300)
      pb[t / 9] = y_b;
  endtask

  initial begin
    logic [6:0] lfsr;
    int t;
    int ones;

    // PRBS-7 reference stream from the seed.
    lfsr = 7'h7F;
    for (int i = 0; i < 127; i++) begin
      prbs[i] = lfsr[6];
      lfsr    = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end

    // Table: 3 reset cycles, one full default frame, then the next sync MSB.
    for (int i = 0; i < 40; i++) begin
      tbl[i].rst   = (i < 3);
      tbl[i].exp_y = 1'b0;
    end
    for (int k = 0; k < 8; k++)  tbl[3 + k].exp_y = c_sync[7 - k];
    for (int k = 0; k < 24; k++) tbl[11 + k].exp_y = c_pay_hand[23 - k];
    tbl[39].exp_y = 1'b1;

    reset = 1'b0;
    #1 reset = 1'b1;

    for (int i = 0; i < 40; i++) begin
      reset = tbl[i].rst;
      @(posedge clk);
      @(negedge clk);
      check("table_a", i - 3, y_a, tbl[i].exp_y);
      if (i >= 3) check_bc("table", i - 3);
    end

    // Free run: three default frames and beyond, two max-length frames,
    // and 254 one-bit payload frames.
    for (t = 37; t < 2300; t++) begin
      @(posedge clk);
      @(negedge clk);
      check("run_a", t, y_a, model_y(t, 24, 4));
      check_bc("run", t);
    end

    // Explicit sync recurrence at frame starts 36 and 72 (cycles 37, 73).
    // Already covered by the model run; here PRBS-7 properties on dut_b.
    ones = 0;
    for (int i = 0; i < 127; i++) begin
      check("prbs_period", i, pb[i + 127], pb[i]);
      if (pb[i] === 1'b1) ones++;
    end
    checks++;
    if (ones != 64) begin
      errors++;
      $display("FAIL prbs_ones got %0d expected 64", ones);
    end

    // Advance dut_a into the middle of a payload, then reset between edges.
    while ((t % 36) < 10 || (t % 36) > 30) begin
      @(posedge clk);
      @(negedge clk);
      check("pre_rst_a", t, y_a, model_y(t, 24, 4));
      t++;
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_a", t, y_a, 1'b0);
    check("async_rst_b", t, y_b, 1'b0);
    check("async_rst_c", t, y_c, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_a", t, y_a, 1'b0);
    reset = 1'b0;

    for (int u = 0; u < 120; u++) begin
      @(posedge clk);
      @(negedge clk);
      check("after_rst_a", u, y_a, model_y(u, 24, 4));
      check_bc("after_rst", u);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
